hmac_sha256_digest_tx: RTL
==========================

Name: hmac_sha256_digest_tx

Overview:
- Transmit side of the HMAC-SHA256 test link. The bench feeds 10-bit command packets into the core; this block carries results back the other way.
- Captures a completed digest from the core in parallel and serialises it, most-significant byte first, into 10-bit ring packets.
- Output handshake is valid-then-yumi, consumed by the FSB trace-replay node.
- Sits between the HMAC core's digest output and the bench or FSB ring.

Parameters:
- digest_width_p, 256, digest width in bits; must be a non-zero multiple of 8.
- ring_width_p, 10, packet width; must be >= 10. Bits above 9 are driven 0.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  reset, asynchronous, active-high
- v_i  input  1  digest valid from core
- digest_i  input  digest_width_p  digest value; sampled only on v_i & ready_o
- ready_o  output  1  block can accept a digest
- v_o  output  1  packet valid toward ring
- data_o  output  ring_width_p  packet: [9]=data flag, [8]=last flag, [7:0]=payload byte
- yumi_i  input  1  consumer takes the packet this cycle; legal only when v_o=1
- busy_o  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset values (asserted asynchronously, held until deassert): state=IDLE, ready_o=1, v_o=0, data_o=0, busy_o=0, byte counter=0, shift register=0.
- Reset mid-frame aborts the frame immediately. v_o falls in the same cycle reset rises, with no partial last packet. The first frame after reset starts clean.
- NB = digest_width_p/8. The byte counter is $clog2(NB+1) bits wide.
- State IDLE:
  - ready_o=1, v_o=0.
  - On v_i & ready_o at edge t: load digest_i into the shift register, set counter=NB, go to SEND.
  - v_o=1 from cycle t+1, so first-packet latency is 1 cycle.
- State SEND:
  - ready_o=0.
  - v_o=1, data_o[9]=1, data_o[7:0]=shift register top byte.
  - data_o[8]=1 only when counter==1 and the checksum feature is compiled out.
  - data_o holds stable while v_o=1 and yumi_i=0. Any number of stall cycles is allowed.
  - On yumi_i: shift left 8, decrement counter.
  - Counter reaching 0 goes to CSUM (feature on) or IDLE (feature off).
- Back-to-back frames:
  - ready_o is registered from state, so a new digest is accepted no earlier than the cycle after the final yumi.
  - v_i while busy is ignored; the core must hold v_i until ready_o.
- yumi_i while v_o=0 is ignored and leaves state unchanged. The bench flags it as a protocol error.
- v_i and yumi_i together in IDLE: v_i is accepted; yumi_i is ignored.
- Throughput is 1 packet per cycle when yumi_i is held high. A frame takes NB cycles (NB+1 with the checksum).
- Bits [ring_width_p-1:10] of data_o are always 0.

Optional Feature:
- Macro: HMAC_TX_CHECKSUM_EN.
- Defined:
  - Adds state CSUM. An 8-bit running XOR of every byte accepted by yumi_i in SEND is cleared on frame load.
  - In CSUM: v_o=1, data_o[9]=0, data_o[8]=1, data_o[7:0]=XOR. On yumi_i go to IDLE.
  - Frame length is NB+1 packets.
- Not defined:
  - No CSUM state and no XOR register.
  - The last data byte carries data_o[8]=1. Frame length is NB packets.

Test Plan:
- Reset then idle: hold reset_i 5 cycles mid-run -> ready_o=1, v_o=0, data_o=0, busy_o=0 immediately and after release.
- Single frame, yumi_i tied 1, digest_i=0x00010203...1F -> 32 packets, data_o=0x200,0x201,...,0x21F. The final packet is 0x31F (feature off). With the feature on, the final byte is 0x21F and packet 33 is 0x100 (XOR of 0x00..0x1F = 0x00).
- Stall: digest 0xFF..FF, yumi_i low 7 cycles at byte 5 -> data_o held at 0x2FF with v_o=1 throughout. The frame still totals 32 data packets. With the feature on, the checksum packet is 0x100.
- Back-to-back: v_i held high with two digests A then B -> B is accepted only the cycle after A's last yumi. No packet is dropped or duplicated; a scoreboard compares all bytes.
- Mid-frame reset: reset_i asserted after 10 of 32 yumis -> v_o drops asynchronously. The next digest produces a complete 32-byte frame starting at its byte 0.
- Protocol misuse: yumi_i pulsed while in IDLE, and v_i toggled during SEND -> no state change and no corruption of the in-flight frame.

Source files
------------

// File: rtl/hmac_sha256_digest_tx.sv
// Captures a finished HMAC-SHA256 digest and serialises it MSB-byte-first into ring packets.
// Optional trailing XOR checksum packet: define HMAC_TX_CHECKSUM_EN.
module hmac_sha256_digest_tx #(
   parameter int digest_width_p = 256,
   parameter int ring_width_p   = 10
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      v_i,
   input  logic [digest_width_p-1:0] digest_i,
   output logic                      ready_o,
   output logic                      v_o,
   output logic [ring_width_p-1:0]   data_o,
   input  logic                      yumi_i,
   output logic                      busy_o
);

   localparam int nb_lp    = digest_width_p / 8;
   localparam int cnt_w_lp = $clog2(nb_lp + 1);

   localparam logic [1:0] idle_s = 2'd0;
   localparam logic [1:0] send_s = 2'd1;
`ifdef HMAC_TX_CHECKSUM_EN
   localparam logic [1:0] csum_s = 2'd2;
`endif

   logic [1:0]                state_r;
   logic [cnt_w_lp-1:0]       cnt_r;
   logic [digest_width_p-1:0] shift_r;
   logic [7:0]                top_byte;
`ifdef HMAC_TX_CHECKSUM_EN
   logic [7:0]                csum_r;
`endif

   assign top_byte = shift_r[digest_width_p-1 -: 8];

   // Handshake outputs come straight off the state register, so reset clears them at once.
   assign ready_o = (state_r == idle_s);
   assign v_o     = (state_r != idle_s);
   assign busy_o  = (state_r != idle_s);

   always_comb begin
      data_o = '0;
      if (state_r == send_s) begin
         data_o[9]   = 1'b1;
         data_o[7:0] = top_byte;
`ifndef HMAC_TX_CHECKSUM_EN
         data_o[8]   = (cnt_r == cnt_w_lp'(1));
`endif
      end
`ifdef HMAC_TX_CHECKSUM_EN
      else if (state_r == csum_s) begin
         data_o[8]   = 1'b1;
         data_o[7:0] = csum_r;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= idle_s;
         cnt_r   <= '0;
         shift_r <= '0;
`ifdef HMAC_TX_CHECKSUM_EN
         csum_r  <= '0;
`endif
      end else begin
         case (state_r)
            idle_s: begin
               if (v_i) begin
                  shift_r <= digest_i;
                  cnt_r   <= cnt_w_lp'(nb_lp);
                  state_r <= send_s;
`ifdef HMAC_TX_CHECKSUM_EN
                  csum_r  <= '0;
`endif
               end
            end
            send_s: begin
               if (yumi_i) begin
                  shift_r <= shift_r << 8;
                  cnt_r   <= cnt_r - cnt_w_lp'(1);
`ifdef HMAC_TX_CHECKSUM_EN
                  csum_r  <= csum_r ^ top_byte;
                  if (cnt_r == cnt_w_lp'(1)) state_r <= csum_s;
`else
                  if (cnt_r == cnt_w_lp'(1)) state_r <= idle_s;
`endif
               end
            end
`ifdef HMAC_TX_CHECKSUM_EN
            csum_s: begin
               if (yumi_i) state_r <= idle_s;
            end
`endif
            default: state_r <= idle_s;
         endcase
      end
   end

endmodule
